// File: rtl/piso_serializer_pkg.sv
// Shared definitions for the serial link: state encoding and counter sizing.
// The receive-side capture register reuses cnt_w() so both ends agree on
// the bit-counter width for a given word size.
package piso_serializer_pkg;

  typedef enum logic {
    IDLE  = 1'b0,
    SHIFT = 1'b1
  } state_t;

  // Bit-counter width for an n-bit word; at least one bit.
  function automatic int cnt_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/piso_serializer.sv
// Parallel-in, serial-out transmitter. Accepts an n-bit word on a
// valid/ready handshake and shifts it out one bit per clock with a framing
// valid and a one-cycle done pulse after the last bit. Words can be
// streamed back to back with no idle gap.
//
//   state | meaning
//   ------+-----------------------------------------------------------
//   IDLE  | no word in flight, ready for a new word
//   SHIFT | transmitting shreg; cnt counts bits already sent
module piso_serializer
  import piso_serializer_pkg::*;
#(
  parameter int n         = 4,
  parameter int MSB_FIRST = 1
) (
  input  logic         clk,
  input  logic         rst,
  input  logic [n-1:0] D,
  input  logic         load_valid,
  output logic         load_ready,
  output logic         sout,
  output logic         sout_valid,
  output logic         done
);

  localparam int               CNT_W = cnt_w(n);
  localparam logic [CNT_W-1:0] LAST  = CNT_W'(n - 1);

  state_t           state, state_next;
  logic [n-1:0]     shreg;
  logic [n-1:0]     shreg_shifted;
  logic [CNT_W-1:0] cnt;
  logic             last_bit;
  logic             accept;

  assign last_bit = (state == SHIFT) && (cnt == LAST);
  assign accept   = load_valid && load_ready;

  // Shift toward the output end, zero-filling behind the data.
  always_comb begin
    if (MSB_FIRST != 0) shreg_shifted = {shreg[n-2:0], 1'b0};
    else                shreg_shifted = {1'b0, shreg[n-1:1]};
  end

  // State register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_next;
  end

  // Next-state: leave SHIFT only when the last bit goes out with no new word.
  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (load_valid) state_next = SHIFT;
      SHIFT:   if (last_bit && !load_valid) state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // Outputs: sout comes straight from shreg so the first bit is visible the
  // cycle after the accepting edge; ready reopens on the last bit to stream.
  always_comb begin
    load_ready = 1'b1;
    sout_valid = 1'b0;
    sout       = 1'b0;
    if (state == SHIFT) begin
      load_ready = last_bit;
      sout_valid = 1'b1;
      sout       = (MSB_FIRST != 0) ? shreg[n-1] : shreg[0];
    end
  end

  // Datapath: load on accept, shift and count mid-word, pulse done after the
  // last bit. Reset aborts any word in flight without a done pulse.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      shreg <= '0;
      cnt   <= '0;
      done  <= 1'b0;
    end else begin
      done <= last_bit;
      if (accept) begin
        shreg <= D;
        cnt   <= '0;
      end else if ((state == SHIFT) && !last_bit) begin
        shreg <= shreg_shifted;
        cnt   <= cnt + 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_piso_serializer.sv
// Bench for piso_serializer: one MSB-first and one LSB-first instance share
// the same inputs. A queue of expected serial bits (one entry per future
// sout_valid cycle) predicts every output, checked on the falling edge.
module tb_piso_serializer;

  localparam int N = 4;

  logic         clk = 1'b0;
  logic         rst;
  logic [N-1:0] D;
  logic         load_valid;
  logic         m_ready, m_sout, m_valid, m_done;
  logic         l_ready, l_sout, l_valid, l_done;

  int n_checks = 0;
  int n_pass   = 0;

  typedef struct {
    logic bm;
    logic bl;
    logic last;
  } ent_t;

  ent_t q[$];
  logic exp_done = 1'b0;

  always #5 clk = ~clk;

  piso_serializer #(.n(N), .MSB_FIRST(1)) dut_m (
    .clk(clk), .rst(rst), .D(D), .load_valid(load_valid),
    .load_ready(m_ready), .sout(m_sout), .sout_valid(m_valid), .done(m_done)
  );

  piso_serializer #(.n(N), .MSB_FIRST(0)) dut_l (
    .clk(clk), .rst(rst), .D(D), .load_valid(load_valid),
    .load_ready(l_ready), .sout(l_sout), .sout_valid(l_valid), .done(l_done)
  );

  task automatic chk(input string tag, input logic obs, input logic exp);
    n_checks++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed %b expected %b at %0t", tag, obs, exp, $time);
  endtask

  task automatic chk_reset_vals(input string tag);
    chk({tag, "_m_sout"},  m_sout,  1'b0);
    chk({tag, "_m_valid"}, m_valid, 1'b0);
    chk({tag, "_m_done"},  m_done,  1'b0);
    chk({tag, "_m_ready"}, m_ready, 1'b1);
    chk({tag, "_l_sout"},  l_sout,  1'b0);
    chk({tag, "_l_valid"}, l_valid, 1'b0);
    chk({tag, "_l_done"},  l_done,  1'b0);
    chk({tag, "_l_ready"}, l_ready, 1'b1);
  endtask

  // One clock: at the falling edge compare outputs with the model, then drive
  // the inputs for the coming rising edge and advance the model across it.
  task automatic step(input logic [N-1:0] d, input logic lv);
    logic ev, em, el, er, acc;
    @(negedge clk);
    ev = (q.size() > 0);
    em = ev ? q[0].bm : 1'b0;
    el = ev ? q[0].bl : 1'b0;
    er = (q.size() <= 1);
    chk("m_valid", m_valid, ev);
    chk("m_sout",  m_sout,  em);
    chk("m_ready", m_ready, er);
    chk("m_done",  m_done,  exp_done);
    chk("l_valid", l_valid, ev);
    chk("l_sout",  l_sout,  el);
    chk("l_ready", l_ready, er);
    chk("l_done",  l_done,  exp_done);
    D          = d;
    load_valid = lv;
    acc      = lv && er;
    exp_done = ev && q[0].last;
    if (ev) void'(q.pop_front());
    if (acc) begin
      for (int k = 0; k < N; k++) begin
        ent_t e;
        e.bm   = d[N-1-k];
        e.bl   = d[k];
        e.last = (k == N - 1);
        q.push_back(e);
      end
    end
  endtask

  task automatic idle(input int cycles);
    for (int i = 0; i < cycles; i++) step(4'h0, 1'b0);
  endtask

  // Abort whatever is in flight with an asynchronous reset between edges.
  task automatic mid_reset();
    @(posedge clk);
    #2 rst = 1'b1;
    #1 chk_reset_vals("async_rst");
    q.delete();
    exp_done   = 1'b0;
    load_valid = 1'b0;
    @(negedge clk);
    rst = 1'b0;
  endtask

  initial begin
    // Reset held with a pending word on the inputs.
    rst = 1'b1; D = 4'hF; load_valid = 1'b1;
    #3  chk_reset_vals("rst_hold0");
    #10 chk_reset_vals("rst_hold1");
    #5  chk_reset_vals("rst_hold2");
    @(negedge clk);
    rst = 1'b0; load_valid = 1'b0;

    // Single words: 1000, then 0010, 0001, 0100.
    step(4'h8, 1'b1); idle(6);
    step(4'h2, 1'b1); idle(6);
    step(4'h1, 1'b1); idle(6);
    step(4'h4, 1'b1); idle(6);

    // Back to back: valid held high, next word offered at the last-bit edge.
    step(4'h8, 1'b1); step(4'h8, 1'b1); step(4'h8, 1'b1); step(4'h8, 1'b1);
    step(4'h4, 1'b1); idle(7);

    // Busy ignore: a word offered while cnt=1 must be dropped.
    step(4'h1, 1'b1); step(4'h0, 1'b0); step(4'h2, 1'b1); idle(6);

    // All-zero word is still framed.
    step(4'h0, 1'b1); idle(6);

    // Reset after two bits of 1111, then a clean word.
    step(4'hF, 1'b1); step(4'h0, 1'b0); step(4'h0, 1'b0);
    mid_reset();
    idle(3);
    step(4'h8, 1'b1); idle(6);

    // Randomized traffic, with an occasional asynchronous reset.
    for (int i = 0; i < 600; i++) begin
      if (i == 300) mid_reset();
      step(4'($urandom_range(0, 15)), ($urandom_range(0, 3) != 0));
    end
    idle(6);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
